speed_sensor_ctrl: RTL and testbench
====================================

Name: speed_sensor_ctrl

Overview:
- Measurement sequencer for the SpeedSensor AXI4-Lite peripheral.
- Synchronises the raw sensor pulse and counts rising edges over a programmable gate window.
- Measures the cycle period between consecutive edges and hands one result per window to the register bank.
- Configuration comes from slave registers; results, flags and irq go back to readable registers and the interrupt line.

Parameters:
- COUNT_W, 16, width of edge count result.
- PERIOD_W, 32, width of period counter/result.
- GATE_W, 32, width of gate length config.
- MIN_GATE, 16, minimum enforced gate length in cycles.

Ports:
- ACLK  in  1  clock; all logic rising-edge.
- ARESET  in  1  asynchronous, active-high reset.
- cfg_enable  in  1  run measurements while high.
- cfg_single_shot  in  1  stop after one window.
- cfg_gate_cycles  in  GATE_W  window length in ACLK cycles.
- cfg_clear  in  1  single-cycle pulse; clears result_valid, overflow, overrun.
- sensor_in  in  1  asynchronous sensor pulse.
- result_count  out  COUNT_W  edges counted in last window.
- result_period  out  PERIOD_W  last complete edge-to-edge period in cycles.
- result_valid  out  1  result available, held until result_ack.
- result_ack  in  1  consumer read result.
- busy  out  1  FSM not IDLE.
- overflow  out  1  sticky; count or period saturated.
- overrun  out  1  sticky; result overwritten before ack.
- irq  out  1  one-cycle pulse per latched result.

Behaviour:
- Reset state: all outputs 0, FSM IDLE, synchroniser flops 0, period counter 0.
- Interface: one clock ACLK; ARESET asynchronous, active-high (assert async, deassert sync to ACLK externally).
- Edge detect:
  - sensor_in passes a 2-flop synchroniser plus a compare flop.
  - edge pulse asserts 3 cycles after a sensor_in rise.
  - Only rising edges are counted.
- Gate length: effective gate G = max(cfg_gate_cycles, MIN_GATE), sampled on entry to MEASURE. Config changes mid-window are ignored.
- FSM states IDLE, MEASURE, LATCH:
  - IDLE: when cfg_enable=1, go to MEASURE next cycle; load gate counter with G-1; clear edge count.
  - MEASURE: gate counter decrements each cycle. At 0, go to LATCH. The window spans exactly G cycles.
  - MEASURE abort: cfg_enable=0 goes to IDLE next cycle; no result, flags untouched.
  - LATCH (1 cycle): copy count/period to result regs; result_valid=1; irq=1.
  - LATCH exit: if cfg_single_shot=1 or cfg_enable=0, go to IDLE; else go to MEASURE and reload gate.
- Count: an edge in the window's final MEASURE cycle belongs to that window. An edge during the LATCH cycle belongs to the next window. Count saturates at 2^COUNT_W-1 and sets overflow.
- Period counter:
  - Free-running across windows; increments every cycle.
  - On an edge, captures value+1 into the period holding reg, then restarts at 0.
  - Saturates at 2^PERIOD_W-1; the holding reg takes the saturated value and overflow sets.
  - result_period = holding reg at LATCH (0 if no edge ever seen).
- Handshake:
  - result_ack with result_valid=1 clears result_valid next cycle.
  - A LATCH while result_valid=1 and no ack that cycle overwrites the result and sets overrun.
  - Ack and LATCH in the same cycle: result_valid stays 1, no overrun.
- cfg_clear: clears result_valid, overflow, overrun next cycle. Flags set in the same cycle win over clear.
- busy = (state != IDLE).

Optional Feature:
- Macro: SPEED_SENSOR_AVG_EN.
- Defined: result_period is the mean of the last 4 captured periods (sum >> 2, PERIOD_W+2 accumulator). The history fills with the first capture after reset or IDLE entry.
- Undefined: result_period is the last captured period; no history registers exist.

Decomposition:
- Package speed_sensor_pkg: state enum (IDLE, MEASURE, LATCH), MIN_GATE default, saturation helper function.
- Sub-module speed_sensor_sync_edge: synchroniser plus rising-edge pulse, 3-cycle latency.

Test Plan:
- Window count: cfg_gate_cycles=100, enable at t0, sensor period 10 (first rise t2) -> result_count=10, result_period=10, irq one pulse at LATCH, result_valid until ack.
- Gate clamp: cfg_gate_cycles=3, single_shot=1 -> MEASURE lasts 16 cycles, then IDLE, busy=0.
- Saturation: PERIOD_W=8, no edges for 300 cycles then one edge -> result_period=255, overflow=1; cfg_clear pulse -> overflow=0.
- Overrun: continuous mode, no ack across two windows -> overrun=1, result holds the second window; ack coinciding with LATCH -> no overrun.
- Abort: cfg_enable drops at cycle 50 of 100 -> IDLE next cycle, no irq, result unchanged.
- Reset mid-MEASURE: assert ARESET asynchronously -> all outputs 0 immediately, FSM IDLE.

Source files
------------

// File: rtl/speed_sensor_pkg.sv
// Shared types and helpers for the SpeedSensor measurement sequencer.
package speed_sensor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LATCH   = 2'd2
  } state_t;

  localparam int MIN_GATE_DEF = 16;

  // Increment that sticks at max; callers cast the result to their own width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
    return (v >= max) ? max : v + 64'd1;
  endfunction

endpackage

// File: rtl/speed_sensor_sync_edge.sv
// Two-flop synchroniser plus compare flop; rise is high one cycle per sensor rising edge,
// and is consumed by logic clocked on the third edge after the input rises.
module speed_sensor_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/speed_sensor_ctrl.sv
// SpeedSensor measurement sequencer: gated edge count plus edge-to-edge period per window.
// Define SPEED_SENSOR_AVG_EN to report the mean of the last 4 periods instead of the last one.
module speed_sensor_ctrl
  import speed_sensor_pkg::*;
#(
  parameter int COUNT_W  = 16,
  parameter int PERIOD_W = 32,
  parameter int GATE_W   = 32,
  parameter int MIN_GATE = MIN_GATE_DEF
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cfg_enable,
  input  logic                cfg_single_shot,
  input  logic [GATE_W-1:0]   cfg_gate_cycles,
  input  logic                cfg_clear,
  input  logic                sensor_in,
  output logic [COUNT_W-1:0]  result_count,
  output logic [PERIOD_W-1:0] result_period,
  output logic                result_valid,
  input  logic                result_ack,
  output logic                busy,
  output logic                overflow,
  output logic                overrun,
  output logic                irq
);

  localparam logic [COUNT_W-1:0]  CMAX = '1;
  localparam logic [PERIOD_W-1:0] PMAX = '1;
  localparam logic [GATE_W-1:0]   GMIN = GATE_W'(MIN_GATE);

  state_t              state, state_nx;
  logic [GATE_W-1:0]   gate_cnt, gate_len;
  logic [COUNT_W-1:0]  edge_cnt;
  logic [PERIOD_W-1:0] per_cnt, per_hold, per_cap, per_out;
  logic                rise, latch, cnt_sat, per_sat;

  speed_sensor_sync_edge u_sync (
    .clk  (ACLK),
    .rst  (ARESET),
    .din  (sensor_in),
    .rise (rise)
  );

  assign gate_len = (cfg_gate_cycles < GMIN) ? GMIN : cfg_gate_cycles;
  assign latch    = (state == LATCH);
  assign busy     = (state != IDLE);
  assign cnt_sat  = rise && (state == MEASURE) && cfg_enable && (edge_cnt == CMAX);
  assign per_sat  = rise && (per_cnt == PMAX);
  assign per_cap  = PERIOD_W'(sat_inc(64'(per_cnt), 64'(PMAX)));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cfg_enable) state_nx = MEASURE;
      MEASURE: if (!cfg_enable) state_nx = IDLE;
               else if (gate_cnt == '0) state_nx = LATCH;
      LATCH:   state_nx = (cfg_single_shot || !cfg_enable) ? IDLE : MEASURE;
      default: state_nx = IDLE;
    endcase
  end

  // Gate length is sampled only when a window starts, so config edits mid-window are ignored.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          gate_cnt <= gate_len - 1'b1;
          edge_cnt <= '0;
        end
        MEASURE: begin
          gate_cnt <= gate_cnt - 1'b1;
          if (rise && edge_cnt != CMAX) edge_cnt <= edge_cnt + 1'b1;
        end
        LATCH: begin
          gate_cnt <= gate_len - 1'b1;
          edge_cnt <= COUNT_W'(rise);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      per_cnt  <= '0;
      per_hold <= '0;
    end else if (rise) begin
      per_cnt  <= '0;
      per_hold <= per_cap;
    end else if (per_cnt != PMAX) begin
      per_cnt  <= per_cnt + 1'b1;
    end
  end

`ifdef SPEED_SENSOR_AVG_EN
  logic [3:0][PERIOD_W-1:0] hist;
  logic                     hist_fill;
  logic [PERIOD_W+1:0]      hist_sum;

  assign hist_sum = {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]} + {2'b00, hist[3]};
  assign per_out  = hist_sum[PERIOD_W+1:2];

  // The first capture after reset or a return to IDLE seeds all four slots.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      hist      <= '0;
      hist_fill <= 1'b1;
    end else begin
      if (rise) begin
        hist      <= hist_fill ? {4{per_cap}} : {hist[2:0], per_cap};
        hist_fill <= 1'b0;
      end
      if (state != IDLE && state_nx == IDLE) hist_fill <= 1'b1;
    end
  end
`else
  assign per_out = per_hold;
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      result_count  <= '0;
      result_period <= '0;
      result_valid  <= 1'b0;
      overflow      <= 1'b0;
      overrun       <= 1'b0;
      irq           <= 1'b0;
    end else begin
      irq <= latch;
      if (latch) begin
        result_count  <= edge_cnt;
        result_period <= per_out;
      end
      if (latch)                         result_valid <= 1'b1;
      else if (cfg_clear || result_ack)  result_valid <= 1'b0;
      // Setting events take priority over a coincident clear.
      if (latch && result_valid && !result_ack) overrun <= 1'b1;
      else if (cfg_clear)                      overrun <= 1'b0;
      if (cnt_sat || per_sat) overflow <= 1'b1;
      else if (cfg_clear)     overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_speed_sensor_ctrl.sv
// Randomised scoreboard bench for speed_sensor_ctrl: a window/edge-timestamp model predicts each result.
module tb_speed_sensor_ctrl;

  localparam int COUNT_W  = 4;
  localparam int PERIOD_W = 8;
  localparam int GATE_W   = 8;
  localparam int CMAX     = 15;
  localparam int PMAX     = 255;
  localparam int R_IDLE = 0, R_EN = 1, R_MEAS = 2, R_LATCH = 3, R_ABORT = 4;

  logic                ACLK = 1'b0;
  logic                ARESET = 1'b1;
  logic                cfg_enable = 1'b0;
  logic                cfg_single_shot = 1'b0;
  logic [GATE_W-1:0]   cfg_gate_cycles = '0;
  logic                cfg_clear = 1'b0;
  logic                sensor_in = 1'b0;
  logic                result_ack = 1'b0;
  logic [COUNT_W-1:0]  result_count;
  logic [PERIOD_W-1:0] result_period;
  logic                result_valid, busy, overflow, overrun, irq;

  speed_sensor_ctrl #(
    .COUNT_W(COUNT_W), .PERIOD_W(PERIOD_W), .GATE_W(GATE_W), .MIN_GATE(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_enable(cfg_enable), .cfg_single_shot(cfg_single_shot),
    .cfg_gate_cycles(cfg_gate_cycles), .cfg_clear(cfg_clear), .sensor_in(sensor_in),
    .result_count(result_count), .result_period(result_period), .result_valid(result_valid),
    .result_ack(result_ack), .busy(busy), .overflow(overflow), .overrun(overrun), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int cyc;
    int cnt;
    int per;
    bit ovf;
    bit ovr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  // Stimulus state
  logic [3:0] sd = '0;
  bit   lvl = 0, quiet = 0, ack_at_latch = 0;
  int   lvl_left = 1, pmin = 1, pmax = 6, ack_pct = 15, clr_pct = 2;

  // Reference model state
  int m_prev = -1, m_cnt = 0, m_hold = 0;
  bit m_valid = 0, m_ovr = 0, m_ovf = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d want %0d", nm, cyc, act, exp);
    end
  endfunction

  // Advance one cycle and drive the random inputs for the new cycle.
  task automatic tick();
    @(posedge ACLK);
    #1;
    cyc++;
    result_ack = ($urandom_range(99) < ack_pct);
    cfg_clear  = ($urandom_range(99) < clr_pct);
    if (quiet) lvl = 0;
    else if (lvl_left <= 1) begin
      lvl      = !lvl;
      lvl_left = $urandom_range(pmax, pmin);
    end else lvl_left--;
    sensor_in = lvl;
    sd = {sd[2:0], lvl};
  endtask

  // Apply the events of the current cycle; role says what the sequencer does in it.
  task automatic model(input int role);
    bit   edge_now, c_sat, p_sat, latch;
    exp_t e;
    int   diff;
    edge_now = sd[2] && !sd[3];
    c_sat = 0;
    p_sat = 0;
    latch = (role == R_LATCH);
    e.cnt = m_cnt;
    e.per = m_hold;
    e.cyc = cyc + 1;
    if (edge_now) begin
      diff   = cyc - m_prev;
      m_prev = cyc;
      p_sat  = diff > PMAX;
      m_hold = p_sat ? PMAX : diff;
    end
    case (role)
      R_EN:    m_cnt = 0;
      R_MEAS:  if (edge_now) begin
                 if (m_cnt == CMAX) c_sat = 1;
                 else m_cnt++;
               end
      R_LATCH: m_cnt = edge_now ? 1 : 0;
      default: ;
    endcase
    if (latch && m_valid && !result_ack) m_ovr = 1;
    else if (cfg_clear) m_ovr = 0;
    if (latch) m_valid = 1;
    else if (cfg_clear || result_ack) m_valid = 0;
    if (c_sat || p_sat) m_ovf = 1;
    else if (cfg_clear) m_ovf = 0;
    if (latch) begin
      e.ovf = m_ovf;
      e.ovr = m_ovr;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    cfg_enable = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      model(R_IDLE);
    end
  endtask

  task automatic settle_check();
    tick();
    chk("valid", result_valid, m_valid);
    chk("overrun", overrun, m_ovr);
    chk("overflow", overflow, m_ovf);
    chk("busy_idle", busy, 0);
    model(R_IDLE);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_count"}, result_count, 0);
    chk({nm, "_period"}, result_period, 0);
    chk({nm, "_valid"}, result_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_overflow"}, overflow, 0);
    chk({nm, "_overrun"}, overrun, 0);
    chk({nm, "_irq"}, irq, 0);
  endtask

  task automatic do_reset(input bit async_check);
    if (async_check) begin
      #3;
      ARESET = 1;
      #1;
      chk_zero("async_rst");
      chk("sb_empty_at_reset", sb.size(), 0);
    end else ARESET = 1;
    cfg_enable = 0; cfg_clear = 0; result_ack = 0; sensor_in = 0;
    cfg_single_shot = 0; cfg_gate_cycles = '0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 0;
    cyc = 0; sd = '0; lvl = 0; lvl_left = 1;
    m_prev = -1; m_cnt = 0; m_hold = 0; m_valid = 0; m_ovr = 0; m_ovf = 0;
    sb.delete();
  endtask

  // One enable episode: nwin windows, optionally aborted at measure cycle abort_at of the last one.
  task automatic episode(input int gcfg, input bit single, input int nwin, input int abort_at);
    int g;
    g = (gcfg < 16) ? 16 : gcfg;
    tick();
    cfg_gate_cycles = GATE_W'(gcfg);
    cfg_single_shot = single;
    cfg_enable = 1;
    model(R_EN);
    for (int k = 0; k < nwin; k++) begin
      for (int i = 0; i < g; i++) begin
        tick();
        if (i == 0) chk("busy_meas", busy, 1);
        cfg_gate_cycles = GATE_W'($urandom);
        cfg_single_shot = 1'($urandom_range(1));
        if (k == nwin - 1 && i == abort_at) begin
          cfg_enable = 0;
          model(R_ABORT);
          tick();
          chk("busy_abort", busy, 0);
          model(R_IDLE);
          return;
        end
        model(R_MEAS);
      end
      tick();
      cfg_gate_cycles = GATE_W'(gcfg);
      if (ack_at_latch) result_ack = 1;
      if (k < nwin - 1) cfg_single_shot = 0;
      else if (single) cfg_single_shot = 1;
      else cfg_enable = 0;
      model(R_LATCH);
    end
    tick();
    cfg_enable = 0;
    model(R_IDLE);
  endtask

  // Scoreboard monitor: every irq pulse must match the next predicted result.
  always @(negedge ACLK) begin
    if (!ARESET && irq === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL irq_unexpected @cycle %0d: got irq 1 want 0", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("irq_cycle", cyc, e.cyc);
        chk("count", result_count, e.cnt);
        chk("period", result_period, e.per);
        chk("valid_at_irq", result_valid, 1);
        chk("overflow_at_irq", overflow, e.ovf);
        chk("overrun_at_irq", overrun, e.ovr);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gc, gg, nw, ab;
    bit ss;
    do_reset(0);
    chk_zero("reset");

    // Steady period-10 train over a 100-cycle window, then consume the result.
    pmin = 5; pmax = 5; ack_pct = 0; clr_pct = 0;
    idle(3);
    episode(100, 1, 1, -1);
    tick(); result_ack = 1; model(R_IDLE);
    settle_check();

    // Gate shorter than the minimum is clamped.
    pmin = 1; pmax = 4;
    episode(3, 1, 1, -1);
    settle_check();

    // Long silence saturates the period; clear drops the flag.
    quiet = 1; idle(300); quiet = 0;
    pmin = 3; pmax = 6;
    episode(20, 1, 1, -1);
    settle_check();
    tick(); cfg_clear = 1; model(R_IDLE);
    settle_check();

    // No ack across windows -> overrun; ack on the latch cycle -> none.
    ack_pct = 0;
    episode(20, 0, 3, -1);
    settle_check();
    tick(); cfg_clear = 1; model(R_IDLE);
    ack_at_latch = 1;
    episode(20, 0, 2, -1);
    settle_check();
    ack_at_latch = 0;

    // Abort halfway through a window.
    ack_pct = 15;
    episode(100, 0, 1, 50);
    settle_check();

    // Asynchronous reset in the middle of a window.
    tick(); cfg_gate_cycles = 8'd40; cfg_enable = 1; model(R_EN);
    for (int i = 0; i < 10; i++) begin tick(); model(R_MEAS); end
    do_reset(1);
    settle_check();

    clr_pct = 2;
    for (int r = 0; r < 40; r++) begin
      pmin = 1; pmax = $urandom_range(12, 1);
      ack_pct = $urandom_range(40);
      gc = $urandom_range(50);
      gg = (gc < 16) ? 16 : gc;
      ss = 1'($urandom_range(1));
      nw = ss ? 1 : $urandom_range(3, 1);
      ab = ($urandom_range(4) == 0) ? $urandom_range(gg - 1) : -1;
      if ($urandom_range(7) == 0) begin quiet = 1; idle($urandom_range(300, 200)); quiet = 0; end
      else idle($urandom_range(20));
      episode(gc, ss, nw, ab);
      settle_check();
    end

    idle(5);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
